// File: rtl/seq_bcd_conv_pkg.sv
// Shared types for the sequential binary-to-BCD converter.
// The constant function sizes the digit count that a given input width needs.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_e;

    // 2**width has floor(width*log10(2))+1 decimal digits, and it is never a
    // power of ten, so that digit count is the smallest with 10**d > 2**width.
    function automatic int min_digits(input int width);
        return (width * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/seq_bcd_conv_if.sv
// Handshake bundle between the producer, the converter and the result consumer.
// master = the side that supplies operands and takes results, slave = the converter.
interface seq_bcd_conv_if #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_W-1:0]       in_bin;
    logic                  in_signed;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_neg;

    modport master (
        output in_valid, in_bin, in_signed, out_ready,
        input  in_ready, out_valid, out_bcd, out_neg
    );

    modport slave (
        input  in_valid, in_bin, in_signed, out_ready,
        output in_ready, out_valid, out_bcd, out_neg
    );
endinterface

// File: rtl/seq_bcd_conv_add3.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/seq_bcd_conv.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one bit per cycle,
// with optional two's complement input and valid/ready on both sides.
module seq_bcd_conv
    import bcd_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_bcd_conv_if.slave  bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    if (IN_W < 2) begin : g_bad_width
        $error("seq_bcd_conv: IN_W must be at least 2");
    end
    if (DIGITS < min_digits(IN_W)) begin : g_bad_digits
        $error("seq_bcd_conv: DIGITS too small for IN_W");
    end

    conv_state_e        state;
    conv_state_e        state_next;
    logic [CNT_W-1:0]   cnt;
    logic [IN_W-1:0]    mag;
    logic               sign;
    logic [BCD_W-1:0]   work_bcd;
    logic [BCD_W-1:0]   adj_bcd;
    logic [BCD_W-1:0]   result_bcd;
    logic               result_neg;
    logic               in_neg;
    logic [IN_W-1:0]    in_mag;

    // Negation mod 2**IN_W maps the most negative value onto its unsigned magnitude.
    assign in_neg = bus.in_signed & bus.in_bin[IN_W-1];
    assign in_mag = in_neg ? (~bus.in_bin) + IN_W'(1) : bus.in_bin;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .digit    (work_bcd[4*i +: 4]),
            .adjusted (adj_bcd[4*i +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_next = SHIFT;
            SHIFT:   if (cnt == '0)     state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // The SHIFT cycle with cnt==0 does no shifting; it latches the finished
    // digits so the output register only ever changes on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            mag        <= '0;
            sign       <= 1'b0;
            work_bcd   <= '0;
            result_bcd <= '0;
            result_neg <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag      <= in_mag;
                        sign     <= in_neg;
                        work_bcd <= '0;
                        cnt      <= CNT_W'(IN_W);
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        work_bcd <= (adj_bcd << 1) | BCD_W'(mag[IN_W-1]);
                        mag      <= mag << 1;
                        cnt      <= cnt - 1'b1;
                    end else begin
                        result_bcd <= work_bcd;
                        result_neg <= sign;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_bcd   = result_bcd;
    assign bus.out_neg   = result_neg;

endmodule

// File: tb/tb_seq_bcd_conv.sv
// Directed bench for seq_bcd_conv: a 16-bit vector table plus handshake and reset
// sequences, and exhaustive 9-bit unsigned / 8-bit signed sweeps against a decimal model.
module tb_seq_bcd_conv;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_bcd_conv_if #(.IN_W(16), .DIGITS(5)) bus16 ();
    seq_bcd_conv_if #(.IN_W(9),  .DIGITS(3)) bus9 ();
    seq_bcd_conv_if #(.IN_W(8),  .DIGITS(3)) bus8 ();

    seq_bcd_conv #(.IN_W(16), .DIGITS(5)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    seq_bcd_conv #(.IN_W(9),  .DIGITS(3)) dut9  (.clk(clk), .rst_n(rst_n), .bus(bus9.slave));
    seq_bcd_conv #(.IN_W(8),  .DIGITS(3)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    typedef struct {
        logic [15:0] bin;
        logic        sgn;
        logic [19:0] bcd;
        logic        neg;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] dec_to_bcd(input int unsigned value);
        logic [31:0]  r;
        int unsigned  v;
        r = '0;
        v = value;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_result16(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!bus16.out_valid && lat < 100);
        check_output("out_valid_rise", 32'(bus16.out_valid), 32'd1);
    endtask

    task automatic apply_stimulus(input logic [15:0] bin, input logic sgn, output int lat);
        @(negedge clk);
        check_output("idle_ready", 32'(bus16.in_ready), 32'd1);
        bus16.in_valid  = 1'b1;
        bus16.in_bin    = bin;
        bus16.in_signed = sgn;
        @(posedge clk);
        #1 bus16.in_valid = 1'b0;
        wait_result16(lat);
    endtask

    task automatic take_result16();
        @(negedge clk);
        bus16.out_ready = 1'b1;
        @(posedge clk);
        #1 bus16.out_ready = 1'b0;
        check_output("valid_drop", 32'(bus16.out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int n;

        vecs[0]  = '{16'd65535, 1'b0, 20'h65535, 1'b0};
        vecs[1]  = '{16'hFFFF,  1'b1, 20'h00001, 1'b1};
        vecs[2]  = '{16'h8000,  1'b1, 20'h32768, 1'b1};
        vecs[3]  = '{16'h0000,  1'b1, 20'h00000, 1'b0};
        vecs[4]  = '{16'h0000,  1'b0, 20'h00000, 1'b0};
        vecs[5]  = '{16'd1234,  1'b0, 20'h01234, 1'b0};
        vecs[6]  = '{16'h7FFF,  1'b1, 20'h32767, 1'b0};
        vecs[7]  = '{16'hFFFE,  1'b1, 20'h00002, 1'b1};
        vecs[8]  = '{16'd40000, 1'b0, 20'h40000, 1'b0};
        vecs[9]  = '{16'h8000,  1'b0, 20'h32768, 1'b0};
        vecs[10] = '{16'd9,     1'b0, 20'h00009, 1'b0};
        vecs[11] = '{16'hD8F0,  1'b1, 20'h10000, 1'b1};

        bus16.in_valid = 1'b0; bus16.in_bin = '0; bus16.in_signed = 1'b0; bus16.out_ready = 1'b0;
        bus9.in_valid  = 1'b0; bus9.in_bin  = '0; bus9.in_signed  = 1'b0; bus9.out_ready  = 1'b0;
        bus8.in_valid  = 1'b0; bus8.in_bin  = '0; bus8.in_signed  = 1'b0; bus8.out_ready  = 1'b0;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        check_output("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        check_output("rst_out_bcd",   32'(bus16.out_bcd),   32'd0);
        check_output("rst_out_neg",   32'(bus16.out_neg),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_output("rst_in_ready", 32'(bus16.in_ready), 32'd1);

        $display("[TB] 16-bit vector table");
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].bin, vecs[i].sgn, lat);
            @(negedge clk);
            check_output($sformatf("latency_%0d", i), 32'(lat), 32'd17);
            check_output($sformatf("bcd_%0d", i), 32'(bus16.out_bcd), 32'(vecs[i].bcd));
            check_output($sformatf("neg_%0d", i), 32'(bus16.out_neg), 32'(vecs[i].neg));
            take_result16();
        end

        $display("[TB] backpressure in DONE");
        apply_stimulus(16'd777, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus16.in_valid  = 1'b1;
            bus16.in_bin    = 16'd1234;
            bus16.in_signed = 1'b0;
            check_output("bp_out_valid", 32'(bus16.out_valid), 32'd1);
            check_output("bp_out_bcd",   32'(bus16.out_bcd),   32'h00777);
            check_output("bp_in_ready",  32'(bus16.in_ready),  32'd0);
        end
        bus16.out_ready = 1'b1;
        @(posedge clk);
        #1 bus16.out_ready = 1'b0;
        check_output("bp_release_ready", 32'(bus16.in_ready),  32'd1);
        check_output("bp_release_valid", 32'(bus16.out_valid), 32'd0);
        @(posedge clk);
        #1 bus16.in_valid = 1'b0;
        check_output("bp_accepted", 32'(bus16.in_ready), 32'd0);
        wait_result16(lat);
        @(negedge clk);
        check_output("bp_latency", 32'(lat), 32'd17);
        check_output("bp_second_bcd", 32'(bus16.out_bcd), 32'h01234);
        take_result16();

        $display("[TB] reset during SHIFT");
        @(negedge clk);
        bus16.in_valid  = 1'b1;
        bus16.in_bin    = 16'd40000;
        bus16.in_signed = 1'b0;
        @(posedge clk);
        #1 bus16.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        check_output("mid_in_ready", 32'(bus16.in_ready), 32'd0);
        check_output("mid_old_bcd",  32'(bus16.out_bcd),  32'h01234);
        rst_n = 1'b0;
        #1;
        check_output("abort_out_valid", 32'(bus16.out_valid), 32'd0);
        check_output("abort_out_bcd",   32'(bus16.out_bcd),   32'd0);
        check_output("abort_out_neg",   32'(bus16.out_neg),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_output("abort_in_ready", 32'(bus16.in_ready), 32'd1);
        apply_stimulus(16'd9, 1'b0, lat);
        @(negedge clk);
        check_output("after_abort_bcd", 32'(bus16.out_bcd), 32'h00009);
        check_output("after_abort_lat", 32'(lat), 32'd17);
        take_result16();

        $display("[TB] 9-bit unsigned sweep");
        bus9.out_ready = 1'b1;
        for (int v = 0; v < 512; v++) begin
            @(negedge clk);
            n = 0;
            while (!bus9.in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            bus9.in_valid  = 1'b1;
            bus9.in_bin    = 9'(v);
            bus9.in_signed = 1'b0;
            @(posedge clk);
            #1 bus9.in_valid = 1'b0;
            n = 0;
            while (!bus9.out_valid && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 50) check_output("u9_timeout", 32'(bus9.out_valid), 32'd1);
            @(negedge clk);
            check_output($sformatf("u9_%0d", v), 32'({bus9.out_neg, bus9.out_bcd}), dec_to_bcd(v));
        end
        bus9.out_ready = 1'b0;

        $display("[TB] 8-bit signed sweep");
        bus8.out_ready = 1'b1;
        for (int s = -128; s < 128; s++) begin
            logic [31:0] exp;
            @(negedge clk);
            n = 0;
            while (!bus8.in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            bus8.in_valid  = 1'b1;
            bus8.in_bin    = 8'(s);
            bus8.in_signed = 1'b1;
            @(posedge clk);
            #1 bus8.in_valid = 1'b0;
            n = 0;
            while (!bus8.out_valid && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 50) check_output("s8_timeout", 32'(bus8.out_valid), 32'd1);
            exp = (s < 0) ? (32'h1000 | dec_to_bcd(-s)) : dec_to_bcd(s);
            @(negedge clk);
            check_output($sformatf("s8_%0d", s), 32'({bus8.out_neg, bus8.out_bcd}), exp);
        end
        bus8.out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: run exceeded 1000000 ns, bad=%0d total=%0d", bad, total);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
